// File: rtl/rtc_slave.sv
`default_nettype none
// ============================================================================
// Module   : rtc_slave
// Brief    : APB-programmable real-time clock (sec/min/hr/day/yr) with a
//            small sec/min/hr alarm table and a signed time-offset command.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_slave #(
    parameter int ALARM_DEPTH = 4
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        tick,
    input  logic        hold,
    input  logic [7:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        alarm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READY = 2'd3
    } apb_state_t;

    localparam logic [7:0] C_ADDR_TIME   = 8'h00;
    localparam logic [7:0] C_ADDR_ALARM  = 8'h04;
    localparam logic [7:0] C_ADDR_OFFSET = 8'h08;

    apb_state_t state_q, state_d;

    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [4:0]  hr_q,  hr_d;
    logic [8:0]  day_q, day_d;
    logic [5:0]  yr_q,  yr_d;
    logic [31:0] prdata_q, prdata_d;
    logic        alarm_q, alarm_d;

    logic [ALARM_DEPTH-1:0]       alm_vld_q, alm_vld_d;
    logic [ALARM_DEPTH-1:0][16:0] alm_val_q, alm_val_d;

    // Field views of the write data (time word, offset and alarm share layout)
    logic [5:0]  w_sec;
    logic [5:0]  w_min;
    logic [4:0]  w_hr;
    logic [8:0]  w_day;
    logic        w_fields_ok;
    logic [31:0] w_time_word;
    logic        w_commit;

    assign w_sec       = pwdata[31:26];
    assign w_min       = pwdata[25:20];
    assign w_hr        = pwdata[19:15];
    assign w_day       = pwdata[14:6];
    assign w_fields_ok = (w_sec < 6'd60) && (w_min < 6'd60) &&
                         (w_hr < 5'd24) && (w_day < 9'd365);
    assign w_time_word = {sec_q, min_q, hr_q, day_q, yr_q};
    // The write takes effect on the edge that leaves READY
    assign w_commit    = (state_q == ST_READY) && pwrite;

    // Offset add: per-field sum with carry into the next field
    logic       w_add_c0, w_add_c1, w_add_c2, w_add_c3;
    logic [5:0] w_add_sec, w_add_min, w_add_yr;
    logic [4:0] w_add_hr;
    logic [8:0] w_add_day;

    assign w_add_c0  = ({1'b0, sec_q} + {1'b0, w_sec}) >= 7'd60;
    assign w_add_sec = sec_q + w_sec - (w_add_c0 ? 6'd60 : 6'd0);
    assign w_add_c1  = ({1'b0, min_q} + {1'b0, w_min} + {6'd0, w_add_c0}) >= 7'd60;
    assign w_add_min = min_q + w_min + {5'd0, w_add_c0} - (w_add_c1 ? 6'd60 : 6'd0);
    assign w_add_c2  = ({1'b0, hr_q} + {1'b0, w_hr} + {5'd0, w_add_c1}) >= 6'd24;
    assign w_add_hr  = hr_q + w_hr + {4'd0, w_add_c1} - (w_add_c2 ? 5'd24 : 5'd0);
    assign w_add_c3  = ({1'b0, day_q} + {1'b0, w_day} + {9'd0, w_add_c2}) >= 10'd365;
    assign w_add_day = day_q + w_day + {8'd0, w_add_c2} - (w_add_c3 ? 9'd365 : 9'd0);
    assign w_add_yr  = yr_q + {5'd0, w_add_c3};

    // Offset subtract: borrow whenever the minuend cannot cover subtrahend+borrow
    logic       w_sub_b0, w_sub_b1, w_sub_b2, w_sub_b3;
    logic [5:0] w_sub_sec, w_sub_min, w_sub_yr;
    logic [4:0] w_sub_hr;
    logic [8:0] w_sub_day;

    assign w_sub_b0  = sec_q < w_sec;
    assign w_sub_sec = sec_q - w_sec + (w_sub_b0 ? 6'd60 : 6'd0);
    assign w_sub_b1  = {1'b0, min_q} < ({1'b0, w_min} + {6'd0, w_sub_b0});
    assign w_sub_min = min_q - w_min - {5'd0, w_sub_b0} + (w_sub_b1 ? 6'd60 : 6'd0);
    assign w_sub_b2  = {1'b0, hr_q} < ({1'b0, w_hr} + {5'd0, w_sub_b1});
    assign w_sub_hr  = hr_q - w_hr - {4'd0, w_sub_b1} + (w_sub_b2 ? 5'd24 : 5'd0);
    assign w_sub_b3  = {1'b0, day_q} < ({1'b0, w_day} + {9'd0, w_sub_b2});
    assign w_sub_day = day_q - w_day - {8'd0, w_sub_b2} + (w_sub_b3 ? 9'd365 : 9'd0);
    assign w_sub_yr  = yr_q - {5'd0, w_sub_b3};

    // Alarm table bookkeeping
    logic [16:0]            w_alm_key;
    logic [ALARM_DEPTH-1:0] w_alm_match;
    logic [ALARM_DEPTH-1:0] w_alm_hit;
    logic [ALARM_DEPTH-1:0] w_alm_free_oh;
    logic                   w_alm_add;
    logic                   w_alm_del;
    logic                   w_time_changed;

    assign w_alm_key     = pwdata[31:15];
    // Lowest clear valid bit as a one-hot; all zeros when the table is full
    assign w_alm_free_oh = ~alm_vld_q & (alm_vld_q + ALARM_DEPTH'(1));
    assign w_alm_add     = w_commit && (paddr == C_ADDR_ALARM) && pwdata[14] &&
                           !(|w_alm_match);
    assign w_alm_del     = w_commit && (paddr == C_ADDR_ALARM) && !pwdata[14];

    for (genvar gi = 0; gi < ALARM_DEPTH; gi++) begin : g_alm
        assign w_alm_match[gi] = alm_vld_q[gi] && (alm_val_q[gi] == w_alm_key);
        assign w_alm_hit[gi]   = alm_vld_q[gi] && (alm_val_q[gi] == {sec_d, min_d, hr_d});
        assign alm_vld_d[gi]   = (w_alm_add && w_alm_free_oh[gi]) ? 1'b1 :
                                 (w_alm_del && w_alm_match[gi])   ? 1'b0 :
                                 alm_vld_q[gi];
        assign alm_val_d[gi]   = (w_alm_add && w_alm_free_oh[gi]) ? w_alm_key :
                                 alm_val_q[gi];
    end

    // Alarm fires only on an edge that moves the time onto a stored entry
    assign w_time_changed = {sec_d, min_d, hr_d, day_d, yr_d} != w_time_word;
    assign alarm_d        = w_time_changed && (|w_alm_hit);

    // APB FSM, read capture, time writes/offsets and tick advance
    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        day_d    = day_q;
        yr_d     = yr_q;
        prdata_d = prdata_q;

        case (state_q)
            ST_IDLE:  if (psel && !penable) state_d = ST_SETUP;
            ST_SETUP: if (psel && penable)  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_READY;
            ST_READY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (!psel) begin
            state_d = ST_IDLE;
        end

        if ((state_q == ST_WAIT) && (state_d == ST_READY) && !pwrite) begin
            prdata_d = w_time_word;
        end

        if (w_commit) begin
            // Any completing write swallows a coincident tick
            if ((paddr == C_ADDR_TIME) && w_fields_ok) begin
                {sec_d, min_d, hr_d, day_d, yr_d} = pwdata;
            end else if ((paddr == C_ADDR_OFFSET) && w_fields_ok) begin
                if (pwdata[5]) begin
                    {sec_d, min_d, hr_d, day_d, yr_d} =
                        {w_add_sec, w_add_min, w_add_hr, w_add_day, w_add_yr};
                end else begin
                    {sec_d, min_d, hr_d, day_d, yr_d} =
                        {w_sub_sec, w_sub_min, w_sub_hr, w_sub_day, w_sub_yr};
                end
            end
        end else if (tick && !hold) begin
            if (sec_q != 6'd59) begin
                sec_d = sec_q + 6'd1;
            end else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) begin
                    min_d = min_q + 6'd1;
                end else begin
                    min_d = 6'd0;
                    if (hr_q != 5'd23) begin
                        hr_d = hr_q + 5'd1;
                    end else begin
                        hr_d = 5'd0;
                        if (day_q != 9'd364) begin
                            day_d = day_q + 9'd1;
                        end else begin
                            day_d = 9'd0;
                            yr_d  = yr_q + 6'd1;
                        end
                    end
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= ST_IDLE;
            sec_q     <= '0;
            min_q     <= '0;
            hr_q      <= '0;
            day_q     <= '0;
            yr_q      <= '0;
            prdata_q  <= '0;
            alarm_q   <= 1'b0;
            alm_vld_q <= '0;
            alm_val_q <= '0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hr_q      <= hr_d;
            day_q     <= day_d;
            yr_q      <= yr_d;
            prdata_q  <= prdata_d;
            alarm_q   <= alarm_d;
            alm_vld_q <= alm_vld_d;
            alm_val_q <= alm_val_d;
        end
    end

    assign pready = (state_q == ST_READY);
    assign prdata = prdata_q;
    assign alarm  = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_slave
// Brief    : Directed, table-driven self-checking bench for rtc_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic        tick;
    logic        hold;
    logic [7:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        alarm;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    rtc_slave #(.ALARM_DEPTH(4)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .tick    (tick),
        .hold    (hold),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pready  (pready),
        .prdata  (prdata),
        .alarm   (alarm)
    );

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_TICK = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;   // OP_TICK: bit0 = hold
        logic [31:0] data;   // OP_TICK: number of tick cycles
        logic [31:0] exp;    // OP_RD: expected prdata
    } vec_t;

    vec_t vecs[$];

    // Packed time word from hand-chosen field values
    function automatic logic [31:0] tw(input int s, input int m, input int h,
                                       input int d, input int y);
        return {s[5:0], m[5:0], h[4:0], d[8:0], y[5:0]};
    endfunction

    task automatic add_vec(input logic [1:0] op, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; also checks pready width and latency from penable
    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic tk, output logic [31:0] rd);
        int n_hi;
        int lat;
        n_hi = 0;
        lat  = 0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; tick = tk;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge pclk); #1;
            if (pready) begin
                n_hi++;
                if (lat == 0) lat = k;
            end else if (n_hi > 0) begin
                break;
            end
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tick = 1'b0;
        rd = prdata;
        check("pready_width", n_hi, 32'd1);
        check("pready_latency", lat, 32'd2);
    endtask

    // One tick cycle, then watch alarm for a few cycles
    task automatic tick_alarm(input string name, input logic exp);
        int   cnt;
        logic first;
        @(posedge pclk); #1; tick = 1'b1;
        @(posedge pclk); #1; tick = 1'b0;
        first = alarm;
        cnt   = alarm ? 1 : 0;
        repeat (3) begin
            @(posedge pclk); #1;
            if (alarm) cnt++;
        end
        check({name, "_first"}, {31'd0, first}, {31'd0, exp});
        check({name, "_count"}, cnt, exp ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] last_rd;
        int          cnt;

        preset = 1'b1; tick = 1'b0; hold = 1'b0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h00; pwdata = 32'h0;
        last_rd = 32'h0;

        repeat (3) @(posedge pclk);
        #1;
        check("reset_pready", {31'd0, pready}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        check("reset_alarm",  {31'd0, alarm},  32'd0);
        preset = 1'b0;

        add_vec(OP_RD,   8'h00, 32'h0,                   32'h0);
        add_vec(OP_WR,   8'h00, 32'h04108041,            32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   32'h04108041);
        add_vec(OP_WR,   8'h08, tw(59, 59, 23, 364, 32), 32'h0);
        add_vec(OP_RD,   8'h10, 32'h0,                   tw(0, 1, 1, 1, 2));
        add_vec(OP_WR,   8'h08, tw(2, 2, 2, 2, 0),       32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   tw(58, 58, 22, 363, 1));
        add_vec(OP_WR,   8'h08, tw(60, 0, 0, 0, 32),     32'h0);
        add_vec(OP_WR,   8'h08, tw(0, 0, 0, 365, 32),    32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   tw(58, 58, 22, 363, 1));
        add_vec(OP_WR,   8'h00, tw(0, 0, 24, 0, 0),      32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   tw(58, 58, 22, 363, 1));
        add_vec(OP_WR,   8'h0C, 32'hFFFFFFFF,            32'h0);
        add_vec(OP_RD,   8'hFC, 32'h0,                   tw(58, 58, 22, 363, 1));
        add_vec(OP_WR,   8'h00, tw(59, 59, 23, 364, 63), 32'h0);
        add_vec(OP_TICK, 8'h00, 32'd1,                   32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   32'h0);
        add_vec(OP_WR,   8'h00, tw(58, 59, 23, 10, 5),   32'h0);
        add_vec(OP_TICK, 8'h00, 32'd3,                   32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   tw(1, 0, 0, 11, 5));
        add_vec(OP_TICK, 8'h01, 32'd10,                  32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   tw(1, 0, 0, 11, 5));
        add_vec(OP_WR,   8'h00, 32'h0,                   32'h0);
        add_vec(OP_WR,   8'h08, tw(1, 0, 0, 0, 0),       32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   tw(59, 59, 23, 364, 63));
        add_vec(OP_WR,   8'h08, tw(1, 0, 0, 0, 32),      32'h0);
        add_vec(OP_RD,   8'h00, 32'h0,                   32'h0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR: begin
                    apb(1'b1, vecs[i].addr, vecs[i].data, 1'b0, rd);
                    check($sformatf("v%0d_prdata_hold", i), rd, last_rd);
                end
                OP_RD: begin
                    apb(1'b0, vecs[i].addr, 32'h0, 1'b0, rd);
                    check($sformatf("v%0d_read", i), rd, vecs[i].exp);
                    last_rd = vecs[i].exp;
                end
                default: begin
                    @(posedge pclk); #1;
                    tick = 1'b1;
                    hold = vecs[i].addr[0];
                    repeat (vecs[i].data) @(posedge pclk);
                    #1;
                    tick = 1'b0;
                    hold = 1'b0;
                end
            endcase
        end

        // Tick held high through a time write: the written value wins
        apb(1'b1, 8'h00, tw(10, 20, 5, 100, 7), 1'b1, rd);
        apb(1'b0, 8'h00, 32'h0, 1'b0, rd);
        check("tick_vs_write", rd, tw(10, 20, 5, 100, 7));

        // Single alarm sec1 min3 hr1
        apb(1'b1, 8'h04, 32'h0430C000, 1'b0, rd);
        apb(1'b1, 8'h00, tw(0, 3, 1, 2, 2), 1'b0, rd);
        tick_alarm("alarm_basic", 1'b1);

        // Fill the table, duplicate and fifth entry are not stored
        apb(1'b1, 8'h04, 32'h0C30C000, 1'b0, rd);
        apb(1'b1, 8'h04, 32'h1C30C000, 1'b0, rd);
        apb(1'b1, 8'h04, 32'h3C30C000, 1'b0, rd);
        apb(1'b1, 8'h04, 32'h1C30C000, 1'b0, rd);
        apb(1'b1, 8'h04, 32'h1430C000, 1'b0, rd);
        apb(1'b1, 8'h00, tw(4, 3, 1, 0, 0), 1'b0, rd);
        tick_alarm("alarm_full_drop", 1'b0);
        apb(1'b1, 8'h00, tw(14, 3, 1, 0, 0), 1'b0, rd);
        tick_alarm("alarm_sec15", 1'b1);

        // Delete frees the lowest entry, which the next add reuses
        apb(1'b1, 8'h04, 32'h04308000, 1'b0, rd);
        apb(1'b1, 8'h00, tw(0, 3, 1, 0, 0), 1'b0, rd);
        tick_alarm("alarm_deleted", 1'b0);
        apb(1'b1, 8'h04, 32'h1430C000, 1'b0, rd);
        apb(1'b1, 8'h00, tw(4, 3, 1, 0, 0), 1'b0, rd);
        tick_alarm("alarm_reused_slot", 1'b1);

        // With one free slot, a duplicate must not consume it
        apb(1'b1, 8'h04, 32'h0C308000, 1'b0, rd);
        apb(1'b1, 8'h04, 32'h1C30C000, 1'b0, rd);
        apb(1'b1, 8'h04, 32'h2430C000, 1'b0, rd);
        apb(1'b1, 8'h00, tw(8, 3, 1, 0, 0), 1'b0, rd);
        tick_alarm("alarm_dup_not_stored", 1'b1);

        // Non-matching delete leaves entries; hr must match too
        apb(1'b1, 8'h04, 32'h7C308000, 1'b0, rd);
        apb(1'b1, 8'h00, tw(6, 3, 1, 9, 9), 1'b0, rd);
        tick_alarm("alarm_nomatch_delete", 1'b1);
        apb(1'b1, 8'h00, tw(6, 3, 2, 0, 0), 1'b0, rd);
        tick_alarm("alarm_hr_mismatch", 1'b0);

        // Make prdata non-zero before the reset test
        apb(1'b0, 8'h00, 32'h0, 1'b0, rd);
        check("pre_reset_read", rd, tw(7, 3, 2, 0, 0));

        // Reset while READY: write aborted, everything cleared
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
        pwdata = tw(30, 30, 12, 200, 40);
        @(posedge pclk); #1;
        penable = 1'b1;
        cnt = 0;
        while (!pready && cnt < 8) begin
            @(posedge pclk); #1;
            cnt++;
        end
        check("rst_mid_ready_seen", {31'd0, pready}, 32'd1);
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("rst_mid_pready", {31'd0, pready}, 32'd0);
        check("rst_mid_prdata", prdata, 32'd0);
        check("rst_mid_alarm",  {31'd0, alarm},  32'd0);
        apb(1'b0, 8'h00, 32'h0, 1'b0, rd);
        check("rst_mid_no_commit", rd, 32'h0);
        apb(1'b1, 8'h00, tw(6, 3, 1, 0, 0), 1'b0, rd);
        tick_alarm("alarm_table_cleared", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_slave.md
RTC_SLAVE -- requirements
Module: rtc_slave

Interface
- REQ-001: Parameter ALARM_DEPTH, default 4; number of alarm table entries.
- REQ-002: One clock and one reset: reset is synchronous and active-high.
- REQ-003: pclk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: preset  input  1  synchronous, active-high reset.
- REQ-005: tick  input  1  one-second advance enable, sampled on the pclk rising edge.
- REQ-006: hold  input  1  when 1, tick is ignored and time is frozen.
- REQ-007: paddr  input  8  APB address.
- REQ-008: psel, penable, pwrite  input  1 each  APB select, enable and direction (1 = write).
- REQ-009: pwdata  input  32  APB write data.
- REQ-010: pready  output  1  APB transfer-complete strobe.
- REQ-011: prdata  output  32  APB read data.
- REQ-012: alarm  output  1  one-cycle alarm pulse.

Function
- REQ-013: Time fields and ranges:
  - sec 0-59
  - min 0-59
  - hr 0-23
  - day 0-364
  - yr 0-63, wrapping 63 -> 0.
- REQ-014: Packed time word layout:
  - [31:26] sec
  - [25:20] min
  - [19:15] hr
  - [14:6] day
  - [5:0] yr.
- REQ-015: Tick, with tick=1 and hold=0 and no committing write: sec increments, with cascaded carries sec -> min -> hr -> day -> yr.
- REQ-016: APB FSM states: IDLE, SETUP, WAIT, READY.
  - IDLE -> SETUP on psel=1, penable=0.
  - SETUP -> WAIT on psel=1, penable=1.
  - WAIT -> READY unconditionally.
  - READY -> IDLE unconditionally.
  - Any state -> IDLE when psel=0.
- REQ-017: pready is 1 only in READY, giving exactly one wait state and a one-cycle pready pulse.
- REQ-018: The write commits on the rising edge that ends READY.
- REQ-019: Reads at any paddr: prdata is loaded with the current packed time on entry to READY; prdata holds that value until the next read.
- REQ-020: Write, paddr 0x00: the time is loaded from pwdata.
  - If any field is out of range, the write is ignored; pready still completes.
- REQ-021: Write, paddr 0x04, alarm command, fields:
  - sec [31:26], min [25:20], hr [19:15]
  - pwdata[14]: 1 = add, 0 = delete.
- REQ-022: Alarm add:
  - Store in the lowest free entry.
  - An exact duplicate of a valid entry is not stored again.
  - Table full: the command is dropped.
- REQ-023: Alarm delete: invalidates any matching entry; no match has no effect.
- REQ-024: Write, paddr 0x08, offset command:
  - pwdata[31:6] is an offset with sec/min/hr/day fields per REQ-014.
  - pwdata[5]: 1 = add, 0 = subtract.
  - pwdata[4:0] are ignored.
- REQ-025: Offset add: per-field add with carry chain sec(60) -> min(60) -> hr(24) -> day(365) -> yr(64 wrap).
- REQ-026: Offset subtract: per-field subtract with borrow chain on the same moduli; yr wraps 0 -> 63.
- REQ-027: An offset command with any out-of-range field is ignored.
- REQ-028: Writes to any other paddr are ignored; pready still completes normally.
- REQ-029: A committing write takes priority over tick in the same cycle; that tick is discarded.
- REQ-030: alarm is registered and pulses high for exactly one cycle after the time changes so that its sec/min/hr equals a valid entry.
  - No pulse while time is unchanged.
  - Day and yr are not compared.
- REQ-031: Multiple matching entries produce a single pulse.

Reset
- REQ-032: While preset=1 at a rising edge:
  - time = 0:0:0 day 0 yr 0
  - all alarm entries invalid
  - FSM = IDLE
  - pready = 0, prdata = 0, alarm = 0.
- REQ-033: Reset mid-transfer aborts the transfer with no commit.

Verification
- REQ-034: Reset, then write pwdata 0x04108041 at 0x00 with tick=0, then read -> prdata 0x04108041; pready high exactly one cycle per transfer, two cycles after penable rises.
- REQ-035: From 59:59:23 day 364 yr 63, one tick -> time 0:0:0 day 0 yr 0.
- REQ-036: From 1:1:1 day 1 yr 1 with tick=0, add offset 59:59:23 day 364 -> 0:1:1 day 1 yr 2; then subtract 2:2:2 day 2 -> 58:58:22 day 363 yr 1.
- REQ-037: Add alarms 0x0430C000, 0x0C30C000, 0x1C30C000, 0x3C30C000, then 0x1C30C000 again -> four valid entries, no duplicate; a fifth distinct add is dropped.
- REQ-038: With alarm hr1 min3 sec1 stored, write 0:3:1 day 2 yr 2, then one tick -> alarm high exactly one cycle.
- REQ-039: Hold=1 with tick=1 for 10 cycles -> time unchanged.
- REQ-040: Tick coincident with a write commit -> time equals the written value.
